// File: rtl/reg_file.sv
// Register file with two combinational read ports, one write port, a
// registered carry flag and an accepted-write counter. Optional forwarding
// of write data to the read ports (BYPASS=1). Indices at or above NREG
// read as zero and are never written.
module reg_file #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 4,
  parameter int BYPASS = 0,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flag_we,
  input  logic             cin,
  output logic             carry,
  output logic [7:0]       wr_count
);

  // NREG extended by one bit so every address value can be range-checked
  localparam logic [AW:0] NREG_W = NREG[AW:0];

  logic [WIDTH-1:0] regs_r [NREG];
  logic             carry_r;
  logic [7:0]       wr_count_r;

  logic             wr_ok_s;
  logic             rd_ok_a_s;
  logic             rd_ok_b_s;
  logic [WIDTH-1:0] rd_reg_a_s;
  logic [WIDTH-1:0] rd_reg_b_s;

  // Address validity: only indices below NREG are backed by storage
  always_comb begin
    wr_ok_s   = 1'b0;
    rd_ok_a_s = 1'b0;
    rd_ok_b_s = 1'b0;
    if (wr_en && ({1'b0, wr_addr} < NREG_W)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    if ({1'b0, rd_addr_a} < NREG_W) begin
      rd_ok_a_s = 1'b1;
    end else begin
      rd_ok_a_s = 1'b0;
    end
    if ({1'b0, rd_addr_b} < NREG_W) begin
      rd_ok_b_s = 1'b1;
    end else begin
      rd_ok_b_s = 1'b0;
    end
  end

  // State update: reset dominates, otherwise write port, counter and flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      carry_r    <= 1'b0;
      wr_count_r <= 8'd0;
    end else begin
      if (wr_ok_s) begin
        regs_r[wr_addr] <= wr_data;
        wr_count_r      <= wr_count_r + 8'd1;
      end
      if (flag_we) begin
        carry_r <= cin;
      end
    end
  end

  // Storage read mux; out-of-range indices return zero
  always_comb begin
    rd_reg_a_s = {WIDTH{1'b0}};
    rd_reg_b_s = {WIDTH{1'b0}};
    if (rd_ok_a_s) begin
      rd_reg_a_s = regs_r[rd_addr_a];
    end else begin
      rd_reg_a_s = {WIDTH{1'b0}};
    end
    if (rd_ok_b_s) begin
      rd_reg_b_s = regs_r[rd_addr_b];
    end else begin
      rd_reg_b_s = {WIDTH{1'b0}};
    end
  end

  // Forwarding is built only when requested, so without it wr_data never
  // reaches the read ports combinationally.
  generate
    if (BYPASS == 1) begin : g_bypass
      // Same-cycle forwarding of an accepted write, per port
      always_comb begin
        rd_data_a = rd_reg_a_s;
        rd_data_b = rd_reg_b_s;
        if (wr_ok_s && (wr_addr == rd_addr_a)) begin
          rd_data_a = wr_data;
        end else begin
          rd_data_a = rd_reg_a_s;
        end
        if (wr_ok_s && (wr_addr == rd_addr_b)) begin
          rd_data_b = wr_data;
        end else begin
          rd_data_b = rd_reg_b_s;
        end
      end
    end else begin : g_no_bypass
      assign rd_data_a = rd_reg_a_s;
      assign rd_data_b = rd_reg_b_s;
    end
  endgenerate

  assign carry    = carry_r;
  assign wr_count = wr_count_r;

endmodule
